// File: rtl/mem_io_arb.sv
// Two-requester scheduler in front of the memory IO_CTRL request/response ports.
// Each requester has a private FIFO. One head is issued per cycle, chosen
// round-robin. The issued request is remembered as a tag for one cycle, so the
// single response stream can be steered back to the requester that owns it.
module mem_io_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic            QClk,
  input  logic            RstQnnnH,
  input  logic            ArbEnQ501H,
  input  logic            Req0ValidQ500H,
  output logic            Req0ReadyQ500H,
  input  logic            Req0OpcodeQ500H,
  input  logic [XLEN-1:0] Req0AddressQ500H,
  input  logic [XLEN-1:0] Req0DataQ500H,
  input  logic            Req1ValidQ500H,
  output logic            Req1ReadyQ500H,
  input  logic            Req1OpcodeQ500H,
  input  logic [XLEN-1:0] Req1AddressQ500H,
  input  logic [XLEN-1:0] Req1DataQ500H,
  output logic            ReqValidQ501H,
  output logic            ReqOpcodeQ501H,
  output logic [XLEN-1:0] ReqAddressQ501H,
  output logic [XLEN-1:0] ReqDataQ501H,
  input  logic            RspValidQ502H,
  input  logic [XLEN-1:0] RspDataQ502H,
  output logic            Rsp0ValidQ503H,
  output logic            Rsp0OpcodeQ503H,
  output logic [XLEN-1:0] Rsp0AddressQ503H,
  output logic [XLEN-1:0] Rsp0DataQ503H,
  output logic            Rsp1ValidQ503H,
  output logic            Rsp1OpcodeQ503H,
  output logic [XLEN-1:0] Rsp1AddressQ503H,
  output logic [XLEN-1:0] Rsp1DataQ503H,
  output logic            ErrUnexpRspQ503H
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + 2 * XLEN;  // {opcode, address, data}

  logic [1:0]    push_valid;
  logic [1:0]    push_ready;
  logic [1:0]    head_valid;
  logic [1:0]    grant;
  logic [EW-1:0] push_entry [2];
  logic [EW-1:0] head_entry [2];

  logic          last_grant_q;
  logic          issue_owner_q;
  logic          tag_valid_q;
  logic          tag_owner_q;
  logic          tag_opcode_q;
  logic [XLEN-1:0] tag_address_q;
  logic          first_cycle_q;
  logic          rsp_fire;

  assign push_valid     = {Req1ValidQ500H, Req0ValidQ500H};
  assign push_entry[0]  = {Req0OpcodeQ500H, Req0AddressQ500H, Req0DataQ500H};
  assign push_entry[1]  = {Req1OpcodeQ500H, Req1AddressQ500H, Req1DataQ500H};
  assign Req0ReadyQ500H = push_ready[0];
  assign Req1ReadyQ500H = push_ready[1];

  // Per-requester FIFO. Ready depends only on the registered count, so a full
  // FIFO refuses a push even in a cycle where its head is being popped.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;

    assign push_ready[gi] = (count_q != CW'(FIFO_DEPTH));
    assign push           = push_valid[gi] & push_ready[gi];
    assign pop            = grant[gi];
    assign head_valid[gi] = (count_q != '0);
    assign head_entry[gi] = mem_q[rd_ptr_q];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
      count_d = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge QClk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry[gi];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge QClk) begin
      if (!RstQnnnH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  // Round-robin grant: when both heads wait, the one not served last wins.
  always_comb begin
    grant = '0;
    if (ArbEnQ501H) begin
      if (head_valid[0] && head_valid[1]) grant = last_grant_q ? 2'b01 : 2'b10;
      else grant = head_valid;
    end
  end

  // Issue stage: register the granted head; fields hold when nothing issues.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      ReqValidQ501H   <= 1'b0;
      ReqOpcodeQ501H  <= 1'b0;
      ReqAddressQ501H <= '0;
      ReqDataQ501H    <= '0;
      issue_owner_q   <= 1'b0;
      last_grant_q    <= 1'b1;
    end else begin
      ReqValidQ501H <= |grant;
      if (|grant) begin
        {ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H} <= grant[1] ? head_entry[1] : head_entry[0];
        issue_owner_q <= grant[1];
        last_grant_q  <= grant[1];
      end
    end
  end

  // Tag of the request whose response is due this cycle.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      tag_valid_q   <= 1'b0;
      tag_owner_q   <= 1'b0;
      tag_opcode_q  <= 1'b0;
      tag_address_q <= '0;
    end else begin
      tag_valid_q   <= ReqValidQ501H;
      tag_owner_q   <= issue_owner_q;
      tag_opcode_q  <= ReqOpcodeQ501H;
      tag_address_q <= ReqAddressQ501H;
    end
  end

  assign rsp_fire = RspValidQ502H & tag_valid_q;

  // Response steering and sticky unexpected-response flag; the check is masked
  // in the first cycle after reset release.
  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      Rsp0ValidQ503H   <= 1'b0;
      Rsp0OpcodeQ503H  <= 1'b0;
      Rsp0AddressQ503H <= '0;
      Rsp0DataQ503H    <= '0;
      Rsp1ValidQ503H   <= 1'b0;
      Rsp1OpcodeQ503H  <= 1'b0;
      Rsp1AddressQ503H <= '0;
      Rsp1DataQ503H    <= '0;
      ErrUnexpRspQ503H <= 1'b0;
      first_cycle_q    <= 1'b1;
    end else begin
      first_cycle_q  <= 1'b0;
      Rsp0ValidQ503H <= rsp_fire & ~tag_owner_q;
      Rsp1ValidQ503H <= rsp_fire & tag_owner_q;
      if (rsp_fire && !tag_owner_q) begin
        Rsp0OpcodeQ503H  <= tag_opcode_q;
        Rsp0AddressQ503H <= tag_address_q;
        Rsp0DataQ503H    <= RspDataQ502H;
      end
      if (rsp_fire && tag_owner_q) begin
        Rsp1OpcodeQ503H  <= tag_opcode_q;
        Rsp1AddressQ503H <= tag_address_q;
        Rsp1DataQ503H    <= RspDataQ502H;
      end
      if (RspValidQ502H && !tag_valid_q && !first_cycle_q) ErrUnexpRspQ503H <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_arb.sv
// Directed bench for mem_io_arb: read timing, round-robin, full FIFO with
// enable, write routing, unexpected response and reset mid-operation.
module tb_mem_io_arb;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic            r0_valid, r0_op, r1_valid, r1_op;
  logic [XLEN-1:0] r0_addr, r0_data, r1_addr, r1_data;
  logic            r0_ready, r1_ready;
  logic            q_valid, q_op;
  logic [XLEN-1:0] q_addr, q_data;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            s0_valid, s0_op, s1_valid, s1_op;
  logic [XLEN-1:0] s0_addr, s0_data, s1_addr, s1_data;
  logic            err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_io_arb #(.FIFO_DEPTH(4), .XLEN(XLEN)) dut (
    .QClk(clk), .RstQnnnH(rst_n), .ArbEnQ501H(arb_en),
    .Req0ValidQ500H(r0_valid), .Req0ReadyQ500H(r0_ready), .Req0OpcodeQ500H(r0_op),
    .Req0AddressQ500H(r0_addr), .Req0DataQ500H(r0_data),
    .Req1ValidQ500H(r1_valid), .Req1ReadyQ500H(r1_ready), .Req1OpcodeQ500H(r1_op),
    .Req1AddressQ500H(r1_addr), .Req1DataQ500H(r1_data),
    .ReqValidQ501H(q_valid), .ReqOpcodeQ501H(q_op), .ReqAddressQ501H(q_addr), .ReqDataQ501H(q_data),
    .RspValidQ502H(rsp_valid), .RspDataQ502H(rsp_data),
    .Rsp0ValidQ503H(s0_valid), .Rsp0OpcodeQ503H(s0_op), .Rsp0AddressQ503H(s0_addr), .Rsp0DataQ503H(s0_data),
    .Rsp1ValidQ503H(s1_valid), .Rsp1OpcodeQ503H(s1_op), .Rsp1AddressQ503H(s1_addr), .Rsp1DataQ503H(s1_data),
    .ErrUnexpRspQ503H(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arb_en = 1'b1;
    r0_valid = 1'b0; r0_op = 1'b0; r0_addr = '0; r0_data = '0;
    r1_valid = 1'b0; r1_op = 1'b0; r1_addr = '0; r1_data = '0;
    rsp_valid = 1'b0; rsp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] exp_addr;
    int k;

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_q_addr", q_addr, 0);
    chk("rst_ready0", 32'(r0_ready), 1);
    chk("rst_ready1", 32'(r1_ready), 1);
    chk("rst_s0_valid", 32'(s0_valid), 0);
    chk("rst_s1_valid", 32'(s1_valid), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // Read timing, requester 0
    r0_valid = 1'b1; r0_op = 1'b0; r0_addr = 32'h0000_1004;
    tick();                                            // cycle 1
    idle_inputs();
    chk("rd_c1_q_valid", 32'(q_valid), 0);
    tick();                                            // cycle 2
    chk("rd_c2_q_valid", 32'(q_valid), 1);
    chk("rd_c2_q_addr", q_addr, 32'h0000_1004);
    chk("rd_c2_q_op", 32'(q_op), 0);
    chk("rd_c2_s1_valid", 32'(s1_valid), 0);
    tick();                                            // cycle 3
    chk("rd_c3_q_valid", 32'(q_valid), 0);
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick();                                            // cycle 4
    rsp_valid = 1'b0; rsp_data = '0;
    chk("rd_c4_s0_valid", 32'(s0_valid), 1);
    chk("rd_c4_s0_data", s0_data, 32'hDEAD_BEEF);
    chk("rd_c4_s0_op", 32'(s0_op), 0);
    chk("rd_c4_s0_addr", s0_addr, 32'h0000_1004);
    chk("rd_c4_s1_valid", 32'(s1_valid), 0);
    chk("rd_c4_err", 32'(err), 0);
    tick();                                            // cycle 5
    chk("rd_c5_s0_valid", 32'(s0_valid), 0);
    chk("rd_c5_s1_valid", 32'(s1_valid), 0);

    // Round-robin: 4 pushes each, issue order 0,1,0,1,... from cycle 2
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      r0_valid = (c < 4); r0_addr = 32'h1000 + 32'(4 * c);
      r1_valid = (c < 4); r1_addr = 32'h2000 + 32'(4 * c);
      rsp_valid = (c >= 3 && c <= 10); rsp_data = 32'hC000 + 32'(c);
      if (c >= 2 && c <= 9) begin
        k = c - 2;
        exp_addr = ((k % 2) != 0) ? 32'h2000 + 32'(4 * (k / 2)) : 32'h1000 + 32'(4 * (k / 2));
        chk("rr_q_valid", 32'(q_valid), 1);
        chk("rr_q_addr", q_addr, exp_addr);
      end else begin
        chk("rr_q_idle", 32'(q_valid), 0);
      end
      if (c >= 4 && c <= 11) begin
        k = c - 4;
        exp_addr = ((k % 2) != 0) ? 32'h2000 + 32'(4 * (k / 2)) : 32'h1000 + 32'(4 * (k / 2));
        if ((k % 2) != 0) begin
          chk("rr_s1_valid", 32'(s1_valid), 1);
          chk("rr_s1_addr", s1_addr, exp_addr);
          chk("rr_s1_data", s1_data, 32'hC000 + 32'(c - 1));
          chk("rr_s0_quiet", 32'(s0_valid), 0);
        end else begin
          chk("rr_s0_valid", 32'(s0_valid), 1);
          chk("rr_s0_addr", s0_addr, exp_addr);
          chk("rr_s0_data", s0_data, 32'hC000 + 32'(c - 1));
          chk("rr_s1_quiet", 32'(s1_valid), 0);
        end
      end else begin
        chk("rr_s0_idle", 32'(s0_valid), 0);
        chk("rr_s1_idle", 32'(s1_valid), 0);
      end
      tick();
    end
    idle_inputs();

    // Full FIFO with enable low, then release
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      arb_en   = (c >= 6);
      r0_valid = (c <= 7);
      r0_addr  = 32'h3000 + 32'(4 * ((c < 4) ? c : 4));
      chk("full_ready0", 32'(r0_ready), (c >= 4 && c <= 6) ? 0 : 1);
      chk("full_ready1", 32'(r1_ready), 1);
      if (c >= 7 && c <= 11) begin
        chk("full_q_valid", 32'(q_valid), 1);
        chk("full_q_addr", q_addr, 32'h3000 + 32'(4 * (c - 7)));
      end else begin
        chk("full_q_idle", 32'(q_valid), 0);
      end
      chk("full_s0_idle", 32'(s0_valid), 0);
      chk("full_err", 32'(err), 0);
      tick();
    end
    idle_inputs();

    // Write routing, requester 1
    do_reset();
    r1_valid = 1'b1; r1_op = 1'b1; r1_addr = 32'h0000_1000; r1_data = 32'h5A5A_5A5A;
    tick();                                            // cycle 1
    idle_inputs();
    tick();                                            // cycle 2
    chk("wr_q_valid", 32'(q_valid), 1);
    chk("wr_q_op", 32'(q_op), 1);
    chk("wr_q_data", q_data, 32'h5A5A_5A5A);
    chk("wr_q_addr", q_addr, 32'h0000_1000);
    tick();                                            // cycle 3
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    tick();                                            // cycle 4
    rsp_valid = 1'b0;
    chk("wr_s1_valid", 32'(s1_valid), 1);
    chk("wr_s1_op", 32'(s1_op), 1);
    chk("wr_s1_addr", s1_addr, 32'h0000_1000);
    chk("wr_s0_valid", 32'(s0_valid), 0);
    tick();
    chk("wr_s1_pulse_end", 32'(s1_valid), 0);

    // Unexpected response
    do_reset();
    chk("unexp_err_before", 32'(err), 0);
    rsp_valid = 1'b1; rsp_data = 32'h7777_7777;
    tick();
    rsp_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("unexp_err_sticky", 32'(err), 1);
      chk("unexp_s0", 32'(s0_valid), 0);
      chk("unexp_s1", 32'(s1_valid), 0);
      tick();
    end

    // Reset mid-operation: 3 queued, 1 in flight, reset one cycle
    do_reset();
    chk("midrst_err_cleared", 32'(err), 0);
    for (int c = 0; c <= 10; c++) begin
      rst_n    = (c != 5);
      arb_en   = (c >= 4);
      r0_valid = (c < 4);
      r0_addr  = 32'h4000 + 32'(4 * c);
      rsp_valid = (c == 6); rsp_data = 32'hBAD0_BAD0;
      if (c == 4) chk("midrst_full", 32'(r0_ready), 0);
      if (c == 5) begin
        chk("midrst_inflight", 32'(q_valid), 1);
        chk("midrst_inflight_addr", q_addr, 32'h4000);
      end
      if (c >= 6) begin
        chk("midrst_q_valid", 32'(q_valid), 0);
        chk("midrst_s0", 32'(s0_valid), 0);
        chk("midrst_s1", 32'(s1_valid), 0);
        chk("midrst_ready0", 32'(r0_ready), 1);
        chk("midrst_err", 32'(err), 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_io_arb.md
Name: mem_io_arb

Overview:
- Two-requester scheduler in front of the mem_wrap IO_CTRL request port (Q501H) and response port (Q502H).
- Buffers each requester's read/write requests in a private FIFO and issues at most one request per cycle, with round-robin arbitration.
- Tags every issued request so that the single memory response stream is steered back to its owner.
- Requester 0 is the ring IO_CTRL; requester 1 is the loader/debug engine.

Parameters:
- FIFO_DEPTH, 4: entries per requester FIFO; power of 2, minimum 2.
- XLEN, 32: address and data width (t_xlen).

Ports:
- QClk  in  1  clock.
- RstQnnnH  in  1  reset; synchronous, active-low.
- ArbEnQ501H  in  1  issue enable; 0 holds all queued requests.
- ReqNValidQ500H  in  1  requester N request valid (N=0,1).
- ReqNReadyQ500H  out  1  requester N FIFO not full.
- ReqNOpcodeQ500H  in  1  RD=0, WR=1.
- ReqNAddressQ500H  in  XLEN  byte address.
- ReqNDataQ500H  in  XLEN  write data.
- ReqValidQ501H  out  1  to memory.
- ReqOpcodeQ501H  out  1  to memory.
- ReqAddressQ501H  out  XLEN  to memory.
- ReqDataQ501H  out  XLEN  to memory.
- RspValidQ502H  in  1  memory response valid.
- RspDataQ502H  in  XLEN  memory response data.
- RspNValidQ503H  out  1  response pulse to requester N.
- RspNOpcodeQ503H  out  1  opcode of the original request.
- RspNAddressQ503H  out  XLEN  address of the original request.
- RspNDataQ503H  out  XLEN  read data; don't-care for WR.
- ErrUnexpRspQ503H  out  1  sticky unexpected-response flag.

Behaviour:
- Reset: all outputs are 0 except ReqNReadyQ500H=1. FIFOs are emptied, the tag is cleared, LastGrant=1 and the error flag is cleared.
- Push: the FIFO accepts an entry when ReqNValidQ500H && ReqNReadyQ500H.
- Ready: equals !full, computed from the registered count only. A full FIFO refuses a push even in a cycle where it pops.
- Count width: $clog2(FIFO_DEPTH+1). Read and write pointers wrap modulo FIFO_DEPTH.
- FIFO visibility: there is no bypass. An entry pushed in cycle N is at the head from N+1.
- Arbitration (combinational, one grant per cycle):
  - No grant while ArbEnQ501H=0.
  - One head valid: that requester is granted.
  - Both heads valid: the requester != LastGrant is granted.
  - LastGrant updates only on a grant.
- Issue registers:
  - On a grant, pop the head and register it into the Q501H outputs, so ReqValidQ501H is high in the next cycle.
  - Otherwise ReqValidQ501H=0 and the other Q501H outputs hold their values.
  - Minimum latency from push to ReqValidQ501H is 2 cycles. Back-to-back issue is allowed every cycle.
- Tag:
  - TagQ502H = {valid, owner, opcode, address} is registered from the Q501H outputs.
  - The memory response arrives exactly 1 cycle after issue.
- Response routing:
  - When RspValidQ502H && tag valid, the next cycle pulses RspNValidQ503H for N = tag owner for exactly one cycle.
  - The same cycle drives Opcode and Address from the tag and Data from RspDataQ502H.
  - The opcode comes from the tag; the memory response opcode is ignored.
  - The other requester's RspValid stays 0.
- Unexpected response:
  - RspValidQ502H && !tag valid sets ErrUnexpRspQ503H in the next cycle; the flag stays set until reset.
  - The response is dropped.
  - Exception: in the first cycle after reset release the check is masked.
- Missing response: a tag valid with RspValidQ502H=0 produces no response pulse and no error.
- Simultaneous push and pop on the same FIFO: the count is unchanged.
- Reset mid-operation: queued and in-flight requests are discarded and no RspNValid pulse follows.

Test Plan:
- Read timing, requester 0: push RD 0x0000_1004 in cycle 0.
  - Required: ReqValidQ501H=1 with address 0x1004 in cycle 2.
  - Bench drives RspDataQ502H=0xDEADBEEF in cycle 3.
  - Required: Rsp0ValidQ503H=1, data 0xDEADBEEF, opcode RD, address 0x1004 in cycle 4; Rsp1ValidQ503H=0 throughout.
- Round-robin: both requesters push 4 requests each back-to-back.
  - Required: Q501H grant order 0,1,0,1,0,1,0,1 on 8 consecutive cycles; responses are routed to matching owners.
- Full FIFO and enable: with ArbEnQ501H=0, requester 0 offers 5 requests.
  - Required: Req0ReadyQ500H drops after the 4th push; the 5th is held and no issues occur.
  - Then set ArbEnQ501H=1. Required: 4 issues on consecutive cycles, Ready returns to 1, and the 5th issues afterwards.
- Write routing, requester 1: push WR 0x1000 with data 0x5A5A5A5A.
  - Required: Q501H shows opcode WR and data 0x5A5A5A5A.
  - Required: two cycles later Rsp1ValidQ503H=1 with opcode WR and address 0x1000.
- Unexpected response: drive RspValidQ502H=1 with no request in flight.
  - Required: ErrUnexpRspQ503H=1 from the next cycle and stays set; no RspNValid pulse.
- Reset mid-operation: 3 requests queued and 1 in flight, then assert RstQnnnH=0 for one cycle.
  - Required: no further Q501H issue and no RspNValid pulse, even though RspValidQ502H=1 arrives in the first cycle after release.
  - Required: Ready=1 and ErrUnexpRspQ503H=0.
